// File: rtl/lns_mvx_sched_if.sv
// Bus bundle for the matrix-vector scheduler: control handshake, A/x RAM
// read ports, LNS MAC pipe operands/result and the y RAM write port.
interface lns_mvx_sched_if #(
    parameter int AW = 6,
    parameter int VW = 3
);
    logic          start;
    logic          busy;
    logic          done;
    logic [AW-1:0] mat_addr;
    logic [15:0]   mat_data;
    logic [VW-1:0] vec_addr;
    logic [15:0]   vec_data;
    logic [15:0]   alua0;
    logic [15:0]   alub0;
    logic [15:0]   aluc0;
    logic [15:0]   alur2;
    logic          y_we;
    logic [VW-1:0] y_addr;
    logic [15:0]   y_data;

    modport master (
        input  start, mat_data, vec_data, alur2,
        output busy, done, mat_addr, vec_addr, alua0, alub0, aluc0,
               y_we, y_addr, y_data
    );

    modport slave (
        output start, mat_data, vec_data, alur2,
        input  busy, done, mat_addr, vec_addr, alua0, alub0, aluc0,
               y_we, y_addr, y_data
    );
endinterface

// File: rtl/lns_mvx_sched.sv
// y = A*x sequencer over a 2-stage LNS MAC pipe; two rows are interleaved
// cycle-by-cycle so each row's accumulator returns exactly when it is next needed.
module lns_mvx_sched #(
    parameter int ROWS = 8,
    parameter int COLS = 8,
    parameter int AW   = 6,
    parameter int VW   = 3
) (
    input logic               sysclk,
    input logic               reset_n,
    lns_mvx_sched_if.master   bus
);
    localparam logic [15:0] LNS_ZERO = 16'h4000;
    localparam int P  = (ROWS + 1) / 2;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW = VW + 1;
    localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);
    localparam logic [RW-1:0] PAIR_LAST = RW'(2 * (P - 1));
    localparam logic [RW-1:0] ROW_PH    = RW'(ROWS);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_e;

    typedef struct packed {
        logic          vld;
        logic          first;
        logic          last;
        logic          phantom;
        logic [VW-1:0] row;
    } tag_t;

    state_e        state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic          slot_q, slot_d;
    logic [RW-1:0] pbase_q, pbase_d;
    logic [1:0]    dcnt_q, dcnt_d;
    logic [RW-1:0] row;
    tag_t          tag0;
    tag_t          tag_q [3:1];
    tag_t          op_t, wb_t;

    assign row = pbase_q + RW'(slot_q);

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        slot_d       = slot_q;
        pbase_d      = pbase_q;
        dcnt_d       = dcnt_q;
        bus.busy     = 1'b0;
        bus.done     = 1'b0;
        bus.mat_addr = '0;
        bus.vec_addr = '0;
        tag0         = '0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_ISSUE;
                    col_d   = '0;
                    slot_d  = 1'b0;
                    pbase_d = '0;
                end
            end
            S_ISSUE: begin
                bus.busy     = 1'b1;
                tag0.vld     = 1'b1;
                tag0.first   = (col_q == '0);
                tag0.last    = (col_q == COL_LAST);
                tag0.phantom = (row == ROW_PH);
                tag0.row     = row[VW-1:0];
                bus.vec_addr = VW'(col_q);
                if (!tag0.phantom)
                    bus.mat_addr = AW'(row) * AW'(COLS) + AW'(col_q);
                slot_d = ~slot_q;
                // Column advances only after both slots of the pair issued it.
                if (slot_q) begin
                    if (col_q == COL_LAST) begin
                        col_d   = '0;
                        pbase_d = pbase_q + RW'(2);
                        if (pbase_q == PAIR_LAST) begin
                            state_d = S_DRAIN;
                            dcnt_d  = '0;
                        end
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
            S_DRAIN: begin
                bus.busy = 1'b1;
                dcnt_d   = dcnt_q + 2'd1;
                if (dcnt_q == 2'd2)
                    state_d = S_DONE;
            end
            default: begin
                bus.done = 1'b1;
                state_d  = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            col_q   <= '0;
            slot_q  <= 1'b0;
            pbase_q <= '0;
            dcnt_q  <= '0;
            tag_q[1] <= '0;
            tag_q[2] <= '0;
            tag_q[3] <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            slot_q  <= slot_d;
            pbase_q <= pbase_d;
            dcnt_q  <= dcnt_d;
            tag_q[1] <= tag0;
            tag_q[2] <= tag_q[1];
            tag_q[3] <= tag_q[2];
        end
    end

    // Stage 1 is the operand phase (RAM data arrives); stage 3 sees the final sum.
    assign op_t = tag_q[1];
    assign wb_t = tag_q[3];

    always_comb begin
        bus.alub0 = (op_t.vld && !op_t.phantom) ? bus.mat_data : LNS_ZERO;
        bus.aluc0 = op_t.vld ? bus.vec_data : LNS_ZERO;
        bus.alua0 = (op_t.vld && !op_t.first && !op_t.phantom) ? bus.alur2 : LNS_ZERO;
        bus.y_we   = wb_t.vld && wb_t.last && !wb_t.phantom;
        bus.y_addr = bus.y_we ? wb_t.row : '0;
        bus.y_data = bus.y_we ? bus.alur2 : '0;
    end
endmodule

// File: tb/tb_lns_mvx_sched.sv
// Bench for lns_mvx_sched: 2x2, 3x2 and 8x8 instances, each with RAM and
// 2-stage LNS MAC pipe models; results checked against a row-fold reference.
module tb_lns_mvx_sched;
    logic sysclk = 1'b0;
    logic reset_n = 1'b0;
    always #5 sysclk = ~sysclk;

    int total = 0;
    int bad = 0;

    lns_mvx_sched_if #(.AW(6), .VW(3)) i2 ();
    lns_mvx_sched_if #(.AW(6), .VW(3)) i3 ();
    lns_mvx_sched_if #(.AW(6), .VW(3)) i8 ();

    lns_mvx_sched #(.ROWS(2), .COLS(2), .AW(6), .VW(3)) u2 (.sysclk(sysclk), .reset_n(reset_n), .bus(i2.master));
    lns_mvx_sched #(.ROWS(3), .COLS(2), .AW(6), .VW(3)) u3 (.sysclk(sysclk), .reset_n(reset_n), .bus(i3.master));
    lns_mvx_sched #(.ROWS(8), .COLS(8), .AW(6), .VW(3)) u8 (.sysclk(sysclk), .reset_n(reset_n), .bus(i8.master));

    // Toy LNS word: bit15 sign, bit14 zero flag, bits13:0 signed log2 in 1/256 steps.
    function automatic real lns_dec(input logic [15:0] v);
        real m;
        if (v[14]) return 0.0;
        m = $exp(real'($signed(v[13:0])) / 256.0 * $ln(2.0));
        return v[15] ? -m : m;
    endfunction

    function automatic logic [15:0] lns_enc(input real r);
        real a;
        real l;
        int  li;
        a = (r < 0.0) ? -r : r;
        if (a < 1.0e-30) return 16'h4000;
        l = $ln(a) / $ln(2.0) * 256.0;
        li = (l >= 0.0) ? $rtoi(l + 0.5) : -$rtoi(-l + 0.5);
        if (li > 8191) li = 8191;
        if (li < -8192) li = -8192;
        return {r < 0.0, 1'b0, li[13:0]};
    endfunction

    function automatic logic [15:0] lns_mac(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        return lns_enc(lns_dec(a) + lns_dec(b) * lns_dec(c));
    endfunction

    logic [15:0] am [3][64];
    logic [15:0] xm [3][8];
    logic [15:0] ps [3];

    always_ff @(posedge sysclk) begin
        i2.mat_data <= am[0][i2.mat_addr];
        i2.vec_data <= xm[0][i2.vec_addr];
        ps[0]       <= lns_mac(i2.alua0, i2.alub0, i2.aluc0);
        i2.alur2    <= ps[0];
        i3.mat_data <= am[1][i3.mat_addr];
        i3.vec_data <= xm[1][i3.vec_addr];
        ps[1]       <= lns_mac(i3.alua0, i3.alub0, i3.aluc0);
        i3.alur2    <= ps[1];
        i8.mat_data <= am[2][i8.mat_addr];
        i8.vec_data <= xm[2][i8.vec_addr];
        ps[2]       <= lns_mac(i8.alua0, i8.alub0, i8.aluc0);
        i8.alur2    <= ps[2];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge sysclk);
        @(negedge sysclk);
    endtask

    // Reference: each row folds its columns through the MAC, starting from LNS zero.
    function automatic logic [15:0] ref_row(input int inst, input int r, input int cols);
        logic [15:0] acc;
        acc = 16'h4000;
        for (int j = 0; j < cols; j++)
            acc = lns_mac(acc, am[inst][r * cols + j], xm[inst][j]);
        return acc;
    endfunction

    typedef struct {
        logic        st;
        logic        ca;
        logic [5:0]  ma;
        logic        b;
        logic        d;
        logic        we;
        logic [2:0]  ya;
        logic [15:0] yd;
    } vec_t;

    function automatic vec_t mk(input logic st, input logic ca, input logic [5:0] ma, input logic b,
                                input logic d, input logic we, input logic [2:0] ya, input logic [15:0] yd);
        vec_t v;
        v = '{st, ca, ma, b, d, we, ya, yd};
        return v;
    endfunction

    vec_t tv [19];
    int   wa [$];
    logic [15:0] wd [$];
    int   wc [$];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc;
        int bc;
        int oerr;
        int cnt;
        logic [15:0] ey [8];

        i2.start = 1'b0;
        i3.start = 1'b0;
        i8.start = 1'b0;
        for (int k = 0; k < 64; k++) begin
            am[0][k] = 16'h4000; am[1][k] = 16'h4000; am[2][k] = 16'h4000;
        end
        for (int k = 0; k < 8; k++) begin
            xm[0][k] = 16'h4000; xm[1][k] = 16'h4000; xm[2][k] = 16'h4000;
        end

        // ---- reset / idle ----
        reset_n = 1'b0;
        repeat (3) step();
        reset_n = 1'b1;
        step();
        chk("rst2.ctl", {i2.busy, i2.done, i2.y_we}, 3'b000);
        chk("rst2.ops", {i2.alua0, i2.alub0} ^ {2{16'h4000}}, 32'h0);
        chk("rst2.opc", i2.aluc0, 16'h4000);
        chk("rst2.addr", {i2.mat_addr, i2.vec_addr, i2.y_addr}, 0);
        chk("rst3.ctl", {i3.busy, i3.done, i3.y_we}, 3'b000);
        chk("rst3.ops", {i3.alua0, i3.alub0} ^ {2{16'h4000}}, 32'h0);
        chk("rst8.ctl", {i8.busy, i8.done, i8.y_we}, 3'b000);
        chk("rst8.ops", {i8.alua0, i8.alub0} ^ {2{16'h4000}}, 32'h0);
        chk("rst8.opc", i8.aluc0, 16'h4000);
        chk("rst8.addr", {i8.mat_addr, i8.vec_addr, i8.y_addr}, 0);

        // ---- 2x2 identity-like job, then back-to-back with ignored starts ----
        am[0][0] = 16'h0000; am[0][1] = 16'h4000; am[0][2] = 16'h4000; am[0][3] = 16'h0000;
        xm[0][0] = 16'h0000; xm[0][1] = 16'h8000;
        tv[0]  = mk(1, 1, 0, 1, 0, 0, 0, 0);
        tv[1]  = mk(0, 1, 2, 1, 0, 0, 0, 0);
        tv[2]  = mk(0, 1, 1, 1, 0, 0, 0, 0);
        tv[3]  = mk(0, 1, 3, 1, 0, 0, 0, 0);
        tv[4]  = mk(0, 0, 0, 1, 0, 0, 0, 0);
        tv[5]  = mk(0, 0, 0, 1, 0, 1, 0, 16'h0000);
        tv[6]  = mk(0, 0, 0, 1, 0, 1, 1, 16'h8000);
        tv[7]  = mk(0, 0, 0, 0, 1, 0, 0, 0);
        tv[8]  = mk(1, 0, 0, 0, 0, 0, 0, 0);
        tv[9]  = mk(1, 1, 0, 1, 0, 0, 0, 0);
        tv[10] = mk(1, 1, 2, 1, 0, 0, 0, 0);
        tv[11] = mk(0, 1, 1, 1, 0, 0, 0, 0);
        tv[12] = mk(1, 1, 3, 1, 0, 0, 0, 0);
        tv[13] = mk(0, 0, 0, 1, 0, 0, 0, 0);
        tv[14] = mk(1, 0, 0, 1, 0, 1, 0, 16'h0000);
        tv[15] = mk(0, 0, 0, 1, 0, 1, 1, 16'h8000);
        tv[16] = mk(1, 0, 0, 0, 1, 0, 0, 0);
        tv[17] = mk(1, 0, 0, 0, 0, 0, 0, 0);
        tv[18] = mk(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 19; i++) begin
            i2.start = tv[i].st;
            step();
            chk($sformatf("tv%0d.busy", i), i2.busy, tv[i].b);
            chk($sformatf("tv%0d.done", i), i2.done, tv[i].d);
            chk($sformatf("tv%0d.y_we", i), i2.y_we, tv[i].we);
            if (tv[i].ca) chk($sformatf("tv%0d.mat_addr", i), i2.mat_addr, tv[i].ma);
            if (tv[i].we) begin
                chk($sformatf("tv%0d.y_addr", i), i2.y_addr, tv[i].ya);
                chk($sformatf("tv%0d.y_data", i), i2.y_data, tv[i].yd);
            end
        end
        i2.start = 1'b0;

        // ---- 3x2, odd rows with phantom slot ----
        for (int k = 0; k < 6; k++) am[1][k] = 16'h0000;
        xm[1][0] = 16'h0000; xm[1][1] = 16'h0000;
        wa.delete(); wd.delete(); wc.delete();
        dc = -1; bc = 0;
        i3.start = 1'b1;
        step();
        i3.start = 1'b0;
        for (int c = 0; c < 16; c++) begin
            if (i3.y_we) begin wa.push_back(int'(i3.y_addr)); wd.push_back(i3.y_data); end
            if (i3.done && dc < 0) dc = c;
            if (i3.busy) bc++;
            if (c == 6 || c == 8) begin
                chk($sformatf("3x2.ph_b@%0d", c), i3.alub0, 16'h4000);
                chk($sformatf("3x2.ph_a@%0d", c), i3.alua0, 16'h4000);
            end
            if (c == 7) chk("3x2.row2_b@7", i3.alub0, 16'h0000);
            step();
        end
        chk("3x2.nwrites", wa.size(), 3);
        for (int k = 0; k < wa.size() && k < 3; k++) begin
            chk($sformatf("3x2.wr%0d.addr", k), wa[k], k);
            chk($sformatf("3x2.wr%0d.data", k), wd[k], ref_row(1, k, 2));
        end
        chk("3x2.done_cyc", dc, 11);
        chk("3x2.busy_cycles", bc, 11);

        // ---- abort mid-ISSUE on 8x8 with writes pending ----
        for (int k = 0; k < 64; k++) am[2][k] = 16'($urandom);
        for (int k = 0; k < 8; k++) xm[2][k] = 16'($urandom);
        i8.start = 1'b1;
        step();
        i8.start = 1'b0;
        repeat (16) step();
        reset_n = 1'b0;
        step();
        chk("abort.busy", i8.busy, 1'b0);
        chk("abort.y_we", i8.y_we, 1'b0);
        chk("abort.alub0", i8.alub0, 16'h4000);
        reset_n = 1'b1;
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (i8.y_we || i8.done || i8.busy) cnt++;
        end
        chk("abort.quiet", cnt, 0);

        // ---- random 8x8 job vs reference ----
        for (int k = 0; k < 64; k++) am[2][k] = 16'($urandom);
        for (int k = 0; k < 8; k++) xm[2][k] = 16'($urandom_range(16'hffff, 0) & 16'hbfff);
        for (int r = 0; r < 8; r++) ey[r] = ref_row(2, r, 8);
        wa.delete(); wd.delete(); wc.delete();
        dc = -1; bc = 0; oerr = 0;
        i8.start = 1'b1;
        step();
        i8.start = 1'b0;
        for (int c = 0; c < 76; c++) begin
            if (c < 64) begin
                int p, j, s;
                p = c / 16; j = (c % 16) / 2; s = c % 2;
                if (int'(i8.mat_addr) != (2 * p + s) * 8 + j || int'(i8.vec_addr) != j) oerr++;
            end
            if (i8.y_we) begin
                wa.push_back(int'(i8.y_addr)); wd.push_back(i8.y_data); wc.push_back(c);
            end
            if (i8.done && dc < 0) dc = c;
            if (i8.busy) bc++;
            if (c % 9 == 3) i8.start = 1'b1;
            else i8.start = 1'b0;
            if (c >= 66) i8.start = 1'b0;
            step();
        end
        chk("8x8.issue_order_errs", oerr, 0);
        chk("8x8.nwrites", wa.size(), 8);
        for (int k = 0; k < wa.size() && k < 8; k++) begin
            chk($sformatf("8x8.wr%0d.addr", k), wa[k], k);
            chk($sformatf("8x8.wr%0d.data", k), wd[k], ey[k]);
        end
        if (wc.size() == 8) chk("8x8.last_we_cyc", wc[7], 66);
        chk("8x8.done_cyc", dc, 67);
        chk("8x8.busy_cycles", bc, 67);
        chk("8x8.idle_after", {i8.busy, i8.y_we}, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
